// File: rtl/lru_4way.sv
// True-LRU age tracker for a 4-way set-associative cache: one 2-bit age per way per set.
// Optional macro LRU_FWD_EN forwards a same-set pending update onto the victim query.
module lru_4way #(
  parameter int INDEX_WIDTH = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   update_en,
  input  logic [INDEX_WIDTH-1:0] set_idx,
  input  logic [1:0]             accessed_way,
  input  logic [INDEX_WIDTH-1:0] query_idx,
  output logic [1:0]             victim_way
);

  localparam int NUM_SETS = 2 ** INDEX_WIDTH;

  typedef logic [1:0]       age_t;
  typedef age_t [3:0]       set_ages_t;

  set_ages_t ages_q [NUM_SETS];
  set_ages_t upd_ages;
  set_ages_t query_ages;

  // Ages younger than the touched way shift one step older; older ones keep their place.
  function automatic set_ages_t touch(input set_ages_t cur, input logic [1:0] way);
    set_ages_t nxt;
    age_t      a;
    a = cur[way];
    for (int w = 0; w < 4; w++) begin
      if (w == int'(way))  nxt[w] = 2'd0;
      else if (cur[w] < a) nxt[w] = cur[w] + 2'd1;
      else                 nxt[w] = cur[w];
    end
    return nxt;
  endfunction

  // Highest-indexed way at age 3 wins; no way at age 3 reports way 0.
  function automatic logic [1:0] lru_of(input set_ages_t ages);
    logic [1:0] v;
    v = 2'd0;
    for (int w = 0; w < 4; w++) begin
      if (ages[w] == 2'd3) v = 2'(w);
    end
    return v;
  endfunction

  assign upd_ages = touch(ages_q[set_idx], accessed_way);

  // NOTE: every set is reset explicitly, which is why this is a flop array and not a RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < 4; w++) begin
          ages_q[s][w] <= 2'(w);
        end
      end
    end else if (update_en) begin
      ages_q[set_idx] <= upd_ages;
    end
  end

  // NOTE: query_ages gets its default first so this block never infers a latch.
  always_comb begin
    query_ages = ages_q[query_idx];
`ifdef LRU_FWD_EN
    if (update_en && !reset && (set_idx == query_idx)) query_ages = upd_ages;
`else
`endif
    victim_way = lru_of(query_ages);
  end

endmodule

// File: tb/tb_lru_4way.sv
// Self-checking bench for lru_4way: directed cases plus random traffic against a
// recency-list model (position 0 = most recent, position 3 = victim).
module tb_lru_4way;

  localparam int IW = 7;
  localparam int NS = 2 ** IW;

  logic          clk = 1'b0;
  logic          reset;
  logic          update_en;
  logic [IW-1:0] set_idx;
  logic [1:0]    accessed_way;
  logic [IW-1:0] query_idx;
  logic [1:0]    victim_way;

  int n_cmp = 0;
  int n_err = 0;

  int rec [NS][4];

  lru_4way #(.INDEX_WIDTH(IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .update_en    (update_en),
    .set_idx      (set_idx),
    .accessed_way (accessed_way),
    .query_idx    (query_idx),
    .victim_way   (victim_way)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: victim_way=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++)
      for (int p = 0; p < 4; p++) rec[s][p] = p;
  endtask

  // Move-to-front on the recency list of set s.
  task automatic model_touch(input int s, input int w);
    int pos;
    pos = 0;
    for (int p = 0; p < 4; p++) if (rec[s][p] == w) pos = p;
    for (int p = pos; p > 0; p--) rec[s][p] = rec[s][p-1];
    rec[s][0] = w;
  endtask

  function automatic logic [1:0] model_victim(input int q, input bit upd, input int s, input int w);
    int tmp[4];
    int k;
    for (int p = 0; p < 4; p++) tmp[p] = rec[q][p];
`ifdef LRU_FWD_EN
    if (upd && s == q) begin
      k = 1;
      for (int p = 0; p < 4; p++) if (rec[q][p] != w && k < 4) begin tmp[k] = rec[q][p]; k++; end
      tmp[0] = w;
    end
`else
    k = upd ? s + w : 0;
`endif
    return 2'(tmp[3]);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    update_en = 1'b0;
    #1;
    check("reset_async", victim_way, 2'd3);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic do_access(input int s, input int w, input int q);
    update_en    = 1'b1;
    set_idx      = IW'(s);
    accessed_way = 2'(w);
    query_idx    = IW'(q);
    #1;
    check("pre_edge", victim_way, model_victim(q, 1'b1, s, w));
    @(posedge clk);
    model_touch(s, w);
    #1;
    update_en = 1'b0;
  endtask

  task automatic query(input string tag, input int q, input int exp_const);
    update_en = 1'b0;
    query_idx = IW'(q);
    #1;
    check(tag, victim_way, 2'(exp_const));
    check({tag, "_model"}, victim_way, model_victim(q, 1'b0, 0, 0));
  endtask

  task automatic run_pattern(input int s, input int w0, input int w1, input int w2, input int exp_v);
    do_reset();
    do_access(s, w0, s);
    do_access(s, w1, s);
    do_access(s, w2, s);
    query("pattern", s, exp_v);
  endtask

  initial begin
    int sets[5];
    sets = '{3, 12, 47, 63, 127};
    reset = 1'b1; update_en = 1'b0; set_idx = '0; accessed_way = '0; query_idx = '0;
    model_reset();
    #2;
    for (int q = 0; q < NS; q += 31) begin
      query_idx = IW'(q);
      #1;
      check("reset_state", victim_way, 2'd3);
    end
    @(negedge clk);
    reset = 1'b0;

    foreach (sets[i]) begin
      run_pattern(sets[i], 1, 2, 3, 0);
      run_pattern(sets[i], 0, 2, 3, 1);
      run_pattern(sets[i], 0, 1, 3, 2);
      run_pattern(sets[i], 0, 1, 2, 3);
    end

    // Set independence.
    do_reset();
    do_access(12, 0, 12); do_access(12, 1, 12); do_access(12, 2, 12);
    query("indep_47", 47, 3);
    query("indep_12", 12, 3);
    do_access(12, 3, 47);
    query("indep_12_after", 12, 0);
    query("indep_47_after", 47, 3);

    // Repeated MRU access.
    do_reset();
    do_access(9, 2, 9); do_access(9, 2, 9);
    query("repeat_mru", 9, 3);

    // Async reset between edges.
    do_reset();
    do_access(20, 0, 20); do_access(20, 1, 20); do_access(20, 3, 20);
    query("pre_midreset", 20, 2);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_reset", victim_way, 2'd3);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Same-set update and query before the edge.
    update_en = 1'b1; set_idx = IW'(5); accessed_way = 2'd3; query_idx = IW'(5);
    #1;
`ifdef LRU_FWD_EN
    check("fwd_same_set", victim_way, 2'd2);
`else
    check("fwd_same_set", victim_way, 2'd3);
`endif
    @(posedge clk);
    model_touch(5, 3);
    #1;
    update_en = 1'b0;

    // Random traffic with occasional reset; small set range forces collisions.
    for (int it = 0; it < 2000; it++) begin
      int s, w, q;
      bit u;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        continue;
      end
      u = 1'($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NS - 1)) : int'($urandom_range(0, 7));
      w = int'($urandom_range(0, 3));
      q = ($urandom_range(0, 1) == 0) ? s : int'($urandom_range(0, 7));
      update_en = u; set_idx = IW'(s); accessed_way = 2'(w); query_idx = IW'(q);
      #1;
      check("random", victim_way, model_victim(q, u, s, w));
      @(posedge clk);
      if (u) model_touch(s, w);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
